sa_out_drain: RTL and testbench

- Read-side controller for the systolic array's accumulated results.
- After a compute pass it steps `channel_out_en` once per output channel and captures the full `sa_out` bus.
- It then serializes the captured channel column-by-column onto a valid/ready stream toward the writeback/requant path.
- When all channels are drained it pulses `channel_out_reset` to clear the array's output registers for the next pass.

---
 rtl/sa_out_drain.sv | 204 ++++++++++++++++++++
 tb/tb_sa_out_drain.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_out_drain.sv
// sa_out_drain: read-side controller for the systolic array's accumulated results.
// After a compute pass it shifts the SA output chain one channel at a time,
// captures the full sa_out bus, and serializes it column-by-column onto a
// valid/ready stream. When every channel is drained it pulses channel_out_reset.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle drain request (ignored unless idle)
//   mode                SA precision mode, latched at start, echoed on m_mode
//   num_channels        channels to drain (0..ROW_NUM), latched at start
//   num_columns         active columns per channel (1..COLUMN_NUM), latched at start
//   sa_out              SA output bus, column c at [2*PIXEL_WIDTH*c +: 2*PIXEL_WIDTH]
//   channel_out_en      to SA: advance to the next output channel
//   channel_out_reset   to SA: clear the output chain
//   busy, done          activity flag and one-cycle completion pulse
//   m_valid/m_ready     output stream handshake
//   m_data              {pixel_hi, pixel_lo} of the current column
//   m_channel/m_column  beat coordinates
//   m_mode, m_last      latched mode, last beat of the last channel
module sa_out_drain #(
  parameter int unsigned ROW_NUM     = 32,
  parameter int unsigned COLUMN_NUM  = 32,
  parameter int unsigned PIXEL_WIDTH = 20,
  parameter int unsigned CW          = $clog2(ROW_NUM) + 1,
  parameter int unsigned XW          = $clog2(COLUMN_NUM) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                mode,
  input  logic [CW-1:0]                       num_channels,
  input  logic [XW-1:0]                       num_columns,
  input  logic [2*PIXEL_WIDTH*COLUMN_NUM-1:0] sa_out,
  output logic                                channel_out_en,
  output logic                                channel_out_reset,
  output logic                                busy,
  output logic                                done,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [2*PIXEL_WIDTH-1:0]            m_data,
  output logic [CW-2:0]                       m_channel,
  output logic [XW-2:0]                       m_column,
  output logic                                m_mode,
  output logic                                m_last
);

  localparam int unsigned BW   = 2 * PIXEL_WIDTH;
  localparam int unsigned SAW  = BW * COLUMN_NUM;
  localparam int unsigned CHW  = CW - 1;
  localparam int unsigned COLW = XW - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPT,
    S_SEND,
    S_CLEAR
  } state_e;

  state_e          state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic [COLW-1:0] col_q, col_d;
  logic [SAW-1:0]  cap_q, cap_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   num_ch_q, num_ch_d;
  logic [XW-1:0]   num_col_q, num_col_d;

  logic            chan_en_q, chan_en_d;
  logic            chan_rst_q, chan_rst_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            m_valid_q, m_valid_d;
  logic [BW-1:0]   m_data_q, m_data_d;
  logic [CHW-1:0]  m_channel_q, m_channel_d;
  logic [COLW-1:0] m_column_q, m_column_d;
  logic            m_mode_q, m_mode_d;
  logic            m_last_q, m_last_d;

  logic            last_col_c;
  logic            last_ch_c;
  logic            xfer_c;

  // Position of the current beat within the latched pass
  assign last_col_c = (XW'(col_q) + XW'(1)) == num_col_q;
  assign last_ch_c  = (CW'(ch_q) + CW'(1)) == num_ch_q;
  assign xfer_c     = m_valid_q & m_ready;

  // Next-state logic; output registers are loaded from the next-state view so
  // every output changes in the same cycle the state does.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    col_d     = col_q;
    cap_d     = cap_q;
    mode_d    = mode_q;
    num_ch_d  = num_ch_q;
    num_col_d = num_col_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d    = mode;
          num_ch_d  = num_channels;
          num_col_d = num_columns;
          ch_d      = '0;
          col_d     = '0;
          state_d   = (num_channels == '0) ? S_CLEAR : S_SHIFT;
        end
      end
      S_SHIFT: state_d = S_CAPT;
      S_CAPT: begin
        // sa_out has carried the new channel since the cycle after the shift
        cap_d   = sa_out;
        col_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (xfer_c) begin
          if (!last_col_c) begin
            col_d = col_q + COLW'(1);
          end else if (!last_ch_c) begin
            ch_d    = ch_q + CHW'(1);
            state_d = S_SHIFT;
          end else begin
            state_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    chan_en_d   = (state_d == S_SHIFT);
    chan_rst_d  = (state_d == S_CLEAR);
    done_d      = (state_d == S_CLEAR);
    busy_d      = (state_d != S_IDLE);
    m_valid_d   = (state_d == S_SEND);
    m_mode_d    = mode_d;
    m_data_d    = '0;
    m_channel_d = '0;
    m_column_d  = '0;
    m_last_d    = 1'b0;
    if (state_d == S_SEND) begin
      m_data_d    = cap_d[BW*col_d +: BW];
      m_channel_d = ch_d;
      m_column_d  = col_d;
      m_last_d    = ((CW'(ch_d) + CW'(1)) == num_ch_d) &&
                    ((XW'(col_d) + XW'(1)) == num_col_d);
    end
  end

  // State, context and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      col_q       <= '0;
      cap_q       <= '0;
      mode_q      <= 1'b0;
      num_ch_q    <= '0;
      num_col_q   <= '0;
      chan_en_q   <= 1'b0;
      chan_rst_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_channel_q <= '0;
      m_column_q  <= '0;
      m_mode_q    <= 1'b0;
      m_last_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      col_q       <= col_d;
      cap_q       <= cap_d;
      mode_q      <= mode_d;
      num_ch_q    <= num_ch_d;
      num_col_q   <= num_col_d;
      chan_en_q   <= chan_en_d;
      chan_rst_q  <= chan_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_channel_q <= m_channel_d;
      m_column_q  <= m_column_d;
      m_mode_q    <= m_mode_d;
      m_last_q    <= m_last_d;
    end
  end

  assign channel_out_en    = chan_en_q;
  assign channel_out_reset = chan_rst_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign m_valid           = m_valid_q;
  assign m_data            = m_data_q;
  assign m_channel         = m_channel_q;
  assign m_column          = m_column_q;
  assign m_mode            = m_mode_q;
  assign m_last            = m_last_q;

endmodule

// File: tb/tb_sa_out_drain.sv
// Self-checking bench for sa_out_drain: table of drain passes plus hand-written
// stall, mode-latch/second-start and reset-abort sequences. Includes a small
// SA output-chain model driven by channel_out_en / channel_out_reset.
module tb_sa_out_drain;

  localparam int ROW  = 32;
  localparam int COL  = 32;
  localparam int PW   = 20;
  localparam int CW   = $clog2(ROW) + 1;
  localparam int XW   = $clog2(COL) + 1;
  localparam int BW   = 2 * PW;
  localparam int SAW  = BW * COL;
  localparam int BUNW = 3 + BW + (CW - 1) + (XW - 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            mode;
  logic [CW-1:0]   num_channels;
  logic [XW-1:0]   num_columns;
  logic [SAW-1:0]  sa_out;
  logic            channel_out_en;
  logic            channel_out_reset;
  logic            busy;
  logic            done;
  logic            m_valid;
  logic            m_ready;
  logic [BW-1:0]   m_data;
  logic [CW-2:0]   m_channel;
  logic [XW-2:0]   m_column;
  logic            m_mode;
  logic            m_last;

  sa_out_drain #(.ROW_NUM(ROW), .COLUMN_NUM(COL), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .num_channels(num_channels), .num_columns(num_columns), .sa_out(sa_out),
    .channel_out_en(channel_out_en), .channel_out_reset(channel_out_reset),
    .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_channel(m_channel), .m_column(m_column),
    .m_mode(m_mode), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // Pixel pattern: hi half encodes the column, lo half encodes the channel
  function automatic logic [PW-1:0] pix_hi(input int c);
    return PW'(32'h7c68 + 32'haa * c);
  endfunction
  function automatic logic [PW-1:0] pix_lo(input int ch);
    return PW'(32'hc2 + 2 * ch);
  endfunction

  // SA output chain model: each channel_out_en presents the next channel
  int sa_ptr;
  always @(posedge clk) begin
    if (reset || channel_out_reset) sa_ptr <= 0;
    else if (channel_out_en)        sa_ptr <= sa_ptr + 1;
  end
  always_comb begin
    sa_out = '0;
    for (int c = 0; c < COL; c++) sa_out[c*BW +: BW] = {pix_hi(c), pix_lo(sa_ptr - 1)};
  end

  int edge_cnt = 0;
  int s_mark   = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int          cyc;
    int          ch;
    int          col;
    logic [BW-1:0] data;
    logic        last;
    logic        md;
  } beat_t;

  beat_t beats[$];
  int    en_q[$];
  int    rst_q[$];
  int    done_q[$];
  int    stall_viol = 0;
  int    both_viol  = 0;
  logic            prev_valid = 1'b0;
  logic            prev_ready = 1'b0;
  logic [BUNW-1:0] prev_bun   = '0;

  // Negedge monitor: logs events relative to the start edge
  always @(negedge clk) begin
    int rel;
    logic [BUNW-1:0] bun;
    beat_t b;
    rel = edge_cnt - s_mark;
    bun = {m_valid, m_data, m_channel, m_column, m_last, m_mode};
    if (channel_out_en) en_q.push_back(rel);
    if (channel_out_reset) rst_q.push_back(rel);
    if (done) done_q.push_back(rel);
    if (channel_out_en && channel_out_reset) both_viol++;
    if (prev_valid && !prev_ready && !reset && bun != prev_bun) stall_viol++;
    if (m_valid && m_ready) begin
      b.cyc = rel; b.ch = int'(m_channel); b.col = int'(m_column);
      b.data = m_data; b.last = m_last; b.md = m_mode;
      beats.push_back(b);
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_bun   = bun;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs;
    beats.delete(); en_q.delete(); rst_q.delete(); done_q.delete();
  endtask

  // Runs one pass from start to done with optional stall / hostile inputs
  task automatic run(input int nch, input int ncol, input bit md,
                     input int stall_n, input bit toggle, input bit sec);
    int stall_left;
    bit sent;
    bit seen;
    stall_left = stall_n; sent = 0; seen = 0;
    clr_logs();
    num_channels = CW'(nch); num_columns = XW'(ncol); mode = md;
    m_ready = 1'b1; start = 1'b1; s_mark = edge_cnt;
    for (int k = 0; k < 5000 && !seen; k++) begin
      tick();
      start = 1'b0;
      if (done) seen = 1;
      if (toggle) begin
        mode = ~mode;
        num_channels = CW'($urandom_range(0, ROW));
        num_columns  = XW'($urandom_range(1, COL));
      end
      if (sec && !sent && m_valid) begin start = 1'b1; sent = 1; end
      m_ready = 1'b1;
      if (stall_left > 0 && m_valid && m_channel == 0 && m_column == 1) begin
        m_ready = 1'b0;
        stall_left--;
      end
    end
    check("done_seen", longint'(seen), 1);
    start = 1'b0; num_channels = CW'(nch); num_columns = XW'(ncol); mode = md; m_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Compares the logged pass against hand-derived timing and content
  task automatic check_run(input int nch, input int ncol, input bit md, input int stall_n);
    int exp_done;
    int bad;
    int n;
    exp_done = nch * (2 + ncol) + 1 + stall_n;
    n = nch * ncol;
    check("done_count", done_q.size(), 1);
    check("done_cycle", (done_q.size() > 0) ? done_q[0] : -1, exp_done);
    check("clear_count", rst_q.size(), 1);
    check("clear_cycle", (rst_q.size() > 0) ? rst_q[0] : -1, exp_done);
    check("en_count", en_q.size(), nch);
    check("beat_count", beats.size(), n);
    bad = 0;
    if (stall_n == 0)
      for (int i = 0; i < en_q.size(); i++)
        if (en_q[i] != 1 + i * (2 + ncol)) bad++;
    check("en_timing", bad, 0);
    bad = 0;
    for (int i = 0; i < beats.size() && i < n; i++) begin
      int ech;
      int ecol;
      ech = i / ncol; ecol = i % ncol;
      if (beats[i].ch != ech || beats[i].col != ecol ||
          beats[i].data !== {pix_hi(ecol), pix_lo(ech)} ||
          beats[i].last !== (i == n - 1) || beats[i].md !== md ||
          (stall_n == 0 && beats[i].cyc != 3 + ech * (2 + ncol) + ecol)) begin
        if (bad < 4)
          $display("beat %0d differs: ch=%0d col=%0d data=%h last=%b mode=%b cyc=%0d",
                   i, beats[i].ch, beats[i].col, beats[i].data, beats[i].last,
                   beats[i].md, beats[i].cyc);
        bad++;
      end
    end
    check("beat_content", bad, 0);
    check("idle_busy", longint'(busy), 0);
    check("idle_valid", longint'(m_valid), 0);
    check("stall_hold", stall_viol, 0);
    check("en_clear_overlap", both_viol, 0);
  endtask

  typedef struct {
    int nch;
    int ncol;
    bit md;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [BW-1:0] k0;
    logic [BW-1:0] k3;
    bit hit;
    vecs.push_back('{0, 4, 1'b0});
    vecs.push_back('{2, 2, 1'b0});
    vecs.push_back('{1, 1, 1'b1});
    vecs.push_back('{3, 5, 1'b0});
    vecs.push_back('{4, 32, 1'b1});
    vecs.push_back('{ROW, COL, 1'b0});

    reset = 1'b1; start = 1'b0; mode = 1'b0; num_channels = '0;
    num_columns = '0; m_ready = 1'b1;
    repeat (3) tick();
    check("rst_en", longint'(channel_out_en), 0);
    check("rst_clear", longint'(channel_out_reset), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_valid", longint'(m_valid), 0);
    check("rst_data", longint'(m_data), 0);
    check("rst_last", longint'(m_last), 0);
    check("rst_mode", longint'(m_mode), 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run(vecs[i].nch, vecs[i].ncol, vecs[i].md, 0, 1'b0, 1'b0);
      check_run(vecs[i].nch, vecs[i].ncol, vecs[i].md, 0);
    end

    // Reference pass with literal expected pixels and shift cycles
    run(2, 2, 1'b0, 0, 1'b0, 1'b0);
    k0 = 40'h07c68000c2;
    k3 = 40'h07d12000c4;
    check("ref_data_00", (beats.size() > 0) ? longint'(beats[0].data) : -1, longint'(k0));
    check("ref_data_11", (beats.size() > 3) ? longint'(beats[3].data) : -1, longint'(k3));
    check("ref_en0", (en_q.size() > 0) ? en_q[0] : -1, 1);
    check("ref_en1", (en_q.size() > 1) ? en_q[1] : -1, 5);
    check("ref_done", (done_q.size() > 0) ? done_q[0] : -1, 9);

    // Back-pressure on beat (0,1) for three cycles
    run(2, 2, 1'b0, 3, 1'b0, 1'b0);
    check_run(2, 2, 1'b0, 3);

    // Hostile inputs mid-drain and a second start while busy
    run(3, 4, 1'b1, 0, 1'b1, 1'b1);
    check_run(3, 4, 1'b1, 0);

    // Reset during channel 1 of 4 aborts without clearing the SA
    clr_logs();
    num_channels = CW'(4); num_columns = XW'(3); mode = 1'b1;
    start = 1'b1; s_mark = edge_cnt; hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      tick();
      start = 1'b0;
      if (m_valid && m_channel == 1) hit = 1;
    end
    check("abort_reached", longint'(hit), 1);
    reset = 1'b1;
    tick();
    check("abort_en", longint'(channel_out_en), 0);
    check("abort_clear", longint'(channel_out_reset), 0);
    check("abort_valid", longint'(m_valid), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_data", longint'(m_data), 0);
    check("abort_chan", longint'(m_channel), 0);
    check("abort_mode", longint'(m_mode), 0);
    reset = 1'b0;
    repeat (4) tick();
    check("abort_no_clear", rst_q.size(), 0);
    check("abort_no_done", done_q.size(), 0);
    check("abort_en_count", en_q.size(), 2);
    mode = 1'b0;
    run(2, 2, 1'b0, 0, 1'b0, 1'b0);
    check_run(2, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
